// File: rtl/ex_stage_reg.sv
// Execute stage: ALU, branch/jump resolution and the EX/MEM pipeline register.
// Taken control flow raises a one-cycle redirect and squashes the next KILL_CYCLES slots.
module ex_stage_reg #(
    parameter int XLEN        = 32,
    parameter int KILL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            w_reg,
    input  logic [1:0]      w_dm,
    input  logic [2:0]      r_dm,
    input  logic [4:0]      alu_op,
    input  logic [1:0]      reg_dest,
    input  logic            alusrc,
    input  logic            pc_sel,
    input  logic            branch,
    input  logic [2:0]      br_type,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [XLEN-1:0] extend_imm,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_4,
    input  logic [4:0]      rd,
    output logic            ex_valid,
    output logic            w_reg_out,
    output logic [1:0]      w_dm_out,
    output logic [2:0]      r_dm_out,
    output logic [1:0]      reg_dest_out,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] pc_4_out,
    output logic [4:0]      rd_out,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    logic [2:0]      kill_cnt;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [4:0]      shamt;
    logic            cond;
    logic            take;
    logic            live;

    assign op_b     = alusrc ? extend_imm : data2;
    assign shamt    = op_b[4:0];
    assign jalr_sum = data1 + extend_imm;
    assign target   = (pc_sel && alusrc) ? {jalr_sum[XLEN-1:1], 1'b0}
                                         : pc + extend_imm;
    assign live     = in_valid && (kill_cnt == 3'd0);
    assign take     = pc_sel || (branch && cond);

    always_comb begin
        alu = '0;
        case (alu_op)
            5'd0:  alu = data1 + op_b;
            5'd1:  alu = data1 - op_b;
            5'd2:  alu = data1 << shamt;
            5'd3:  alu = {{(XLEN-1){1'b0}}, $signed(data1) < $signed(op_b)};
            5'd4:  alu = {{(XLEN-1){1'b0}}, data1 < op_b};
            5'd5:  alu = data1 ^ op_b;
            5'd6:  alu = data1 >> shamt;
            5'd7:  alu = $unsigned($signed(data1) >>> shamt);
            5'd8:  alu = data1 | op_b;
            5'd9:  alu = data1 & op_b;
            5'd10: alu = op_b;
            5'd11: alu = pc + extend_imm;
            default: alu = '0;
        endcase
    end

    // Unlisted funct3 encodings never take the branch.
    always_comb begin
        cond = 1'b0;
        case (br_type)
            3'd0: cond = (data1 == data2);
            3'd1: cond = (data1 != data2);
            3'd4: cond = ($signed(data1) <  $signed(data2));
            3'd5: cond = ($signed(data1) >= $signed(data2));
            3'd6: cond = (data1 <  data2);
            3'd7: cond = (data1 >= data2);
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kill_cnt     <= '0;
            ex_valid     <= 1'b0;
            w_reg_out    <= 1'b0;
            w_dm_out     <= '0;
            r_dm_out     <= '0;
            reg_dest_out <= '0;
            alu_result   <= '0;
            store_data   <= '0;
            pc_4_out     <= '0;
            rd_out       <= '0;
            redirect     <= 1'b0;
            redirect_pc  <= '0;
        end else if (flush) begin
            kill_cnt  <= '0;
            ex_valid  <= 1'b0;
            w_reg_out <= 1'b0;
            w_dm_out  <= '0;
            r_dm_out  <= '0;
            redirect  <= 1'b0;
        end else if (stall) begin
            // Held slot must not re-fire the fetch redirect.
            redirect <= 1'b0;
        end else begin
            ex_valid     <= live;
            w_reg_out    <= live && w_reg;
            w_dm_out     <= live ? w_dm : 2'd0;
            r_dm_out     <= live ? r_dm : 3'd0;
            reg_dest_out <= reg_dest;
            alu_result   <= alu;
            store_data   <= data2;
            pc_4_out     <= pc_4;
            rd_out       <= rd;
            redirect     <= live && take;
            if (live && take) begin
                redirect_pc <= target;
                kill_cnt    <= 3'(KILL_CYCLES);
            end else if (kill_cnt != 3'd0) begin
                kill_cnt <= kill_cnt - 3'd1;
            end
        end
    end

endmodule
